// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM generator: one shared period counter, CH duty comparators, double-buffered period/duty.
// Optional macro PWM_CENTER_ALIGN_EN adds a center_mode input for up/down (center-aligned) counting.
module pwm_multi_ch #(
    parameter int CH    = 4,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
`ifdef PWM_CENTER_ALIGN_EN
    input  logic                  center_mode,
`endif
    input  logic                  enable,
    input  logic                  load,
    input  logic [CNT_W-1:0]      period_in,
    input  logic [CH*CNT_W-1:0]   duty_in,
    output logic [CH-1:0]         pwm_out,
    output logic                  period_tick,
    output logic [CNT_W-1:0]      cnt_out
);

    logic [CNT_W-1:0]    cnt;
    logic                running;
    logic [CNT_W-1:0]    shadow_period;
    logic [CNT_W-1:0]    act_period;
    logic [CH*CNT_W-1:0] shadow_duty;
    logic [CH*CNT_W-1:0] act_duty;

    logic [CNT_W-1:0]    cnt_next;
    logic [CNT_W-1:0]    period_next;
    logic [CH*CNT_W-1:0] duty_next;
    logic                boundary;
    logic [CH-1:0]       pwm_next;
    logic                tick_next;

`ifdef PWM_CENTER_ALIGN_EN
    logic center;
    logic center_next;
    logic down;
    logic down_next;
`endif

    // Idle and the first enabled edge are treated as boundaries so that a
    // fresh run always starts at cnt=0 with the latest shadow values.
    always_comb begin
        boundary = 1'b0;
        cnt_next = '0;
`ifdef PWM_CENTER_ALIGN_EN
        down_next = 1'b0;
`endif
        if (!enable || !running) begin
            boundary = 1'b1;
        end else begin
`ifdef PWM_CENTER_ALIGN_EN
            if (center && down) begin
                if (cnt <= CNT_W'(1)) begin
                    boundary = 1'b1;
                end else begin
                    cnt_next  = cnt - CNT_W'(1);
                    down_next = 1'b1;
                end
            end else if (cnt == act_period) begin
                if (center && (act_period > CNT_W'(1))) begin
                    cnt_next  = cnt - CNT_W'(1);
                    down_next = 1'b1;
                end else begin
                    boundary = 1'b1;
                end
            end else begin
                cnt_next = cnt + CNT_W'(1);
            end
`else
            if (cnt == act_period) begin
                boundary = 1'b1;
            end else begin
                cnt_next = cnt + CNT_W'(1);
            end
`endif
        end
    end

    // A load coinciding with a boundary bypasses the shadow registers.
    always_comb begin
        period_next = act_period;
        duty_next   = act_duty;
        if (boundary) begin
            if (load) begin
                period_next = period_in;
                duty_next   = duty_in;
            end else begin
                period_next = shadow_period;
                duty_next   = shadow_duty;
            end
        end
`ifdef PWM_CENTER_ALIGN_EN
        center_next = boundary ? center_mode : center;
`endif
    end

    // Outputs are compared against the next-state count so they line up with cnt_out.
    always_comb begin
        pwm_next = '0;
        for (int i = 0; i < CH; i++) begin
            pwm_next[i] = enable && (cnt_next < duty_next[i*CNT_W +: CNT_W]);
        end
        tick_next = enable && (cnt_next == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt           <= '0;
            running       <= 1'b0;
            shadow_period <= '0;
            act_period    <= '0;
            shadow_duty   <= '0;
            act_duty      <= '0;
            pwm_out       <= '0;
            period_tick   <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
            center        <= 1'b0;
            down          <= 1'b0;
`endif
        end else begin
            if (load) begin
                shadow_period <= period_in;
                shadow_duty   <= duty_in;
            end
            cnt         <= cnt_next;
            running     <= enable;
            act_period  <= period_next;
            act_duty    <= duty_next;
            pwm_out     <= pwm_next;
            period_tick <= tick_next;
`ifdef PWM_CENTER_ALIGN_EN
            center      <= center_next;
            down        <= down_next;
`endif
        end
    end

    assign cnt_out = cnt;

endmodule
